// File: rtl/clock_pkg.sv
// Shared types and limits for the minute/hour timekeeping stage.
package clock_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StSetHour = 2'b01,
    StSetMin  = 2'b10
  } set_state_e;

  localparam int unsigned MIN_TENS_MAX = 5;
  localparam int unsigned MIN_MAX      = MIN_TENS_MAX * 10 + 9;
  localparam int unsigned HOUR24_MAX   = 23;
  localparam int unsigned HOUR12_MAX   = 12;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter counting MIN_VAL..MAX_VAL; wrap flags the increment that returns to MIN_VAL.
module bcd_mod_counter #(
  parameter int unsigned MAX_VAL = 59,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned RST_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       wrap
);

  localparam logic [3:0] MaxOnes = 4'(MAX_VAL % 10);
  localparam logic [3:0] MaxTens = 4'(MAX_VAL / 10);
  localparam logic [3:0] MinOnes = 4'(MIN_VAL % 10);
  localparam logic [3:0] MinTens = 4'(MIN_VAL / 10);
  localparam logic [3:0] RstOnes = 4'(RST_VAL % 10);
  localparam logic [3:0] RstTens = 4'(RST_VAL / 10);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       at_max;

  assign at_max = (ones_q == MaxOnes) && (tens_q == MaxTens);
  assign wrap   = inc && at_max;

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (inc) begin
      if (at_max) begin
        ones_d = MinOnes;
        tens_d = MinTens;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= RstOnes;
      tens_q <= RstTens;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/clock_minute_hour_counter.sv
// Minute/hour timekeeping with button-driven time setting and a day rollover pulse.
module clock_minute_hour_counter
  import clock_pkg::*;
#(
  parameter int unsigned HOUR_MODE = 24
) (
  input  logic       clkinput,
  input  logic       reset,
  input  logic       sec_carry,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] hour_tens,
  output logic       pm,
  output logic [1:0] set_field,
  output logic       day_carry
);

  if (HOUR_MODE != 24 && HOUR_MODE != 12) begin : g_bad_mode
    $error("HOUR_MODE must be 12 or 24");
  end

  localparam bit          Mode12  = (HOUR_MODE == 12);
  localparam int unsigned HourMax = Mode12 ? HOUR12_MAX : HOUR24_MAX;
  localparam int unsigned HourMin = Mode12 ? 1 : 0;
  localparam int unsigned HourRst = Mode12 ? 12 : 0;

  set_state_e state_q, state_d;
  logic sec_prev_q, mode_prev_q, inc_prev_q;
  logic sec_ev, mode_ev, inc_ev;
  logic min_inc, hour_inc, min_wrap, hour_wrap;
  logic pm_q, pm_d, day_q, day_d;
  logic hour_is_11;

  // Prev registers reset high so a level already present at reset release is not an edge.
  always_ff @(posedge clkinput or posedge reset) begin
    if (reset) begin
      sec_prev_q  <= 1'b1;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      state_q     <= StRun;
      pm_q        <= 1'b0;
      day_q       <= 1'b0;
    end else begin
      sec_prev_q  <= sec_carry;
      mode_prev_q <= mode_btn;
      inc_prev_q  <= inc_btn;
      state_q     <= state_d;
      pm_q        <= pm_d;
      day_q       <= day_d;
    end
  end

  assign sec_ev  = sec_carry & ~sec_prev_q;
  assign mode_ev = mode_btn & ~mode_prev_q;
  assign inc_ev  = inc_btn & ~inc_prev_q;

  assign hour_is_11 = (hour_tens == 4'd1) && (hour_ones == 4'd1);

  always_comb begin
    state_d  = state_q;
    min_inc  = 1'b0;
    hour_inc = 1'b0;
    case (state_q)
      StRun: begin
        min_inc  = sec_ev;
        hour_inc = sec_ev & min_wrap;
        if (mode_ev) state_d = StSetHour;
      end
      StSetHour: begin
        if (mode_ev) state_d = StSetMin;
        else         hour_inc = inc_ev;
      end
      StSetMin: begin
        if (mode_ev) state_d = StRun;
        else         min_inc = inc_ev;
      end
      default: state_d = StRun;
    endcase
  end

  // In 12 h mode the day ends at 11:59 PM; pm flips whenever hours pass 11 -> 12.
  always_comb begin
    pm_d  = 1'b0;
    day_d = 1'b0;
    if (Mode12) begin
      pm_d  = (hour_inc && hour_is_11) ? ~pm_q : pm_q;
      day_d = (state_q == StRun) && hour_inc && hour_is_11 && pm_q;
    end else begin
      day_d = (state_q == StRun) && hour_wrap;
    end
  end

  bcd_mod_counter #(
    .MAX_VAL(MIN_MAX),
    .MIN_VAL(0),
    .RST_VAL(0)
  ) u_min (
    .clk (clkinput),
    .rst (reset),
    .inc (min_inc),
    .ones(min_ones),
    .tens(min_tens),
    .wrap(min_wrap)
  );

  bcd_mod_counter #(
    .MAX_VAL(HourMax),
    .MIN_VAL(HourMin),
    .RST_VAL(HourRst)
  ) u_hour (
    .clk (clkinput),
    .rst (reset),
    .inc (hour_inc),
    .ones(hour_ones),
    .tens(hour_tens),
    .wrap(hour_wrap)
  );

  assign pm        = pm_q;
  assign set_field = state_q;
  assign day_carry = day_q;

endmodule

// File: tb/tb_clock_minute_hour_counter.sv
// Drives a 24 h and a 12 h instance with shared stimulus and scoreboards both against a time model.
module tb_clock_minute_hour_counter;

  typedef struct {
    int h;
    int m;
    int pm;
    int sf;
    int dc;
  } exp_t;

  logic clkinput = 1'b0;
  logic reset = 1'b1;
  logic sec_carry = 1'b0;
  logic mode_btn = 1'b0;
  logic inc_btn = 1'b0;

  logic [3:0] a_mo, a_mt, a_ho, a_ht, b_mo, b_mt, b_ho, b_ht;
  logic       a_pm, a_dc, b_pm, b_dc;
  logic [1:0] a_sf, b_sf;

  int checks = 0;
  int errors = 0;

  // Index 0 models HOUR_MODE=24, index 1 models HOUR_MODE=12.
  int mh[2], mm[2], mpm[2], mdc[2];
  int msf;
  exp_t q24[$];
  exp_t q12[$];

  always #5 clkinput = ~clkinput;

  clock_minute_hour_counter #(.HOUR_MODE(24)) dut24 (
    .clkinput (clkinput),
    .reset    (reset),
    .sec_carry(sec_carry),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .min_ones (a_mo),
    .min_tens (a_mt),
    .hour_ones(a_ho),
    .hour_tens(a_ht),
    .pm       (a_pm),
    .set_field(a_sf),
    .day_carry(a_dc)
  );

  clock_minute_hour_counter #(.HOUR_MODE(12)) dut12 (
    .clkinput (clkinput),
    .reset    (reset),
    .sec_carry(sec_carry),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .min_ones (b_mo),
    .min_tens (b_mt),
    .hour_ones(b_ho),
    .hour_tens(b_ht),
    .pm       (b_pm),
    .set_field(b_sf),
    .day_carry(b_dc)
  );

  task automatic cmp(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mh[0] = 0;
    mh[1] = 12;
    for (int k = 0; k < 2; k++) begin
      mm[k]  = 0;
      mpm[k] = 0;
      mdc[k] = 0;
    end
    msf = 0;
  endtask

  task automatic model_hour_inc(input int k);
    if (k == 0) begin
      mh[0] = (mh[0] + 1) % 24;
    end else if (mh[1] == 11) begin
      mh[1]  = 12;
      mpm[1] = 1 - mpm[1];
    end else if (mh[1] == 12) begin
      mh[1] = 1;
    end else begin
      mh[1] = mh[1] + 1;
    end
  endtask

  task automatic model_events(input bit s, input bit mo, input bit in);
    for (int k = 0; k < 2; k++) begin
      mdc[k] = 0;
      if (msf == 0 && s) begin
        if (mm[k] == 59) begin
          mm[k] = 0;
          if ((k == 0 && mh[0] == 23) || (k == 1 && mh[1] == 11 && mpm[1] == 1)) mdc[k] = 1;
          model_hour_inc(k);
        end else begin
          mm[k] = mm[k] + 1;
        end
      end
      if (!mo && in) begin
        if (msf == 1) model_hour_inc(k);
        if (msf == 2) mm[k] = (mm[k] + 1) % 60;
      end
    end
    if (mo) msf = (msf == 0) ? 1 : (msf == 1) ? 2 : 0;
  endtask

  task automatic push_expect();
    exp_t e;
    e = '{h: mh[0], m: mm[0], pm: mpm[0], sf: msf, dc: mdc[0]};
    q24.push_back(e);
    e = '{h: mh[1], m: mm[1], pm: mpm[1], sf: msf, dc: mdc[1]};
    q12.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (q24.size() == 0 || q12.size() == 0) begin
      cmp("scoreboard empty", 0, 1);
      return;
    end
    e = q24.pop_front();
    cmp("h24 hour", int'(a_ht) * 10 + int'(a_ho), e.h);
    cmp("h24 min", int'(a_mt) * 10 + int'(a_mo), e.m);
    cmp("h24 pm", int'(a_pm), e.pm);
    cmp("h24 set_field", int'(a_sf), e.sf);
    cmp("h24 day_carry", int'(a_dc), e.dc);
    e = q12.pop_front();
    cmp("h12 hour", int'(b_ht) * 10 + int'(b_ho), e.h);
    cmp("h12 min", int'(b_mt) * 10 + int'(b_mo), e.m);
    cmp("h12 pm", int'(b_pm), e.pm);
    cmp("h12 set_field", int'(b_sf), e.sf);
    cmp("h12 day_carry", int'(b_dc), e.dc);
  endtask

  // One-cycle input pulse, then one idle cycle; outputs checked at both following negedges.
  task automatic pulse(input bit s, input bit mo, input bit in);
    sec_carry = s;
    mode_btn  = mo;
    inc_btn   = in;
    model_events(s, mo, in);
    push_expect();
    @(negedge clkinput);
    check_now();
    sec_carry = 1'b0;
    mode_btn  = 1'b0;
    inc_btn   = 1'b0;
    mdc[0] = 0;
    mdc[1] = 0;
    push_expect();
    @(negedge clkinput);
    check_now();
  endtask

  initial begin
    int guard;
    // sec_carry held high through reset release must not count.
    sec_carry = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clkinput);
    model_reset();
    push_expect();
    check_now();
    reset = 1'b0;
    repeat (3) begin
      push_expect();
      @(negedge clkinput);
      check_now();
    end
    sec_carry = 1'b0;
    push_expect();
    @(negedge clkinput);
    check_now();

    // 60 minutes of run time.
    repeat (60) pulse(1'b1, 1'b0, 1'b0);

    // Set 23:59 on the 24 h instance, with a 59 -> 00 wrap check in SET_MIN.
    pulse(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (mh[0] != 23 && guard < 30) begin pulse(1'b0, 1'b0, 1'b1); guard++; end
    pulse(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (mm[0] != 59 && guard < 70) begin pulse(1'b0, 1'b0, 1'b1); guard++; end
    pulse(1'b0, 1'b0, 1'b1);
    guard = 0;
    while (mm[0] != 59 && guard < 70) begin pulse(1'b0, 1'b0, 1'b1); guard++; end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);

    // SET_HOUR ignores sec_carry; then set 11:59 AM on the 12 h instance.
    pulse(1'b0, 1'b1, 1'b0);
    repeat (5) pulse(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!(mh[1] == 11 && mpm[1] == 0) && guard < 30) begin
      pulse(1'b0, 1'b0, 1'b1);
      guard++;
    end
    pulse(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (mm[1] != 59 && guard < 70) begin pulse(1'b0, 1'b0, 1'b1); guard++; end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);

    // Now 11:59 PM, with mode+inc in the same cycle leaving minutes alone.
    pulse(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (!(mh[1] == 11 && mpm[1] == 1) && guard < 30) begin
      pulse(1'b0, 1'b0, 1'b1);
      guard++;
    end
    pulse(1'b0, 1'b1, 1'b1);
    guard = 0;
    while (mm[1] != 59 && guard < 70) begin pulse(1'b0, 1'b0, 1'b1); guard++; end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);

    // mode and sec_carry together in RUN: minute counts and FSM leaves RUN.
    pulse(1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-SET_HOUR.
    #2 reset = 1'b1;
    #1 model_reset();
    push_expect();
    check_now();
    @(negedge clkinput);
    reset = 1'b0;
    push_expect();
    @(negedge clkinput);
    check_now();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
